// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding and
// the iteration-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must hold the values 0..N.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nbit_adder.sv
// Unsigned N-bit ripple-carry adder; the carry-out lands in S[N].
module nbit_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N:0]   S
);

    always_comb begin : ripple
        logic carry;
        carry = 1'b0;
        S     = '0;
        for (int i = 0; i < N; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        S[N] = carry;
    end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential N x N -> 2N unsigned shift-and-add multiplier with start/busy/done handshake.
// Optional build macro MULT_ZERO_SKIP_EN: zero operands complete in one cycle with P=0.
module seq_mult_shift_add
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] P,
    output logic           busy,
    output logic           done
);

    localparam int               CNT_W    = cnt_w(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     hi_q, hi_d;
    logic [N-1:0]     lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   p_q, p_d;

    logic [N-1:0]     addend;
    logic [N:0]       sum;

    assign addend = lo_q[0] ? mcand_q : '0;

    nbit_adder #(.N(N)) u_adder (
        .A (hi_q),
        .B (addend),
        .S (sum)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case leaves one unassigned (no latch).
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mcand_d = A;
                    lo_d    = B;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
`ifdef MULT_ZERO_SKIP_EN
                    if (A == '0 || B == '0) begin
                        state_d = ST_DONE;
                        p_d     = '0;
                    end
`endif
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                // Carry (sum[N]) shifts into hi, sum[0] into the top of lo.
                hi_d  = sum[N:1];
                lo_d  = {sum[0], lo_q[N-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    p_d     = {sum[N:1], sum[0], lo_q[N-1:1]};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign P    = p_q;
    assign busy = (state_q == ST_CALC);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Randomized/directed bench for seq_mult_shift_add at N=4 and N=8 against an A*B reference.
module tb_seq_mult_shift_add;

`ifdef MULT_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [7:0] p4;
    logic       busy4, done4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [15:0] p8;
    logic       busy8, done8;

    int n_vec = 0;
    int n_err = 0;

    seq_mult_shift_add #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .P(p4), .busy(busy4), .done(done4)
    );

    seq_mult_shift_add #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .P(p8), .busy(busy8), .done(done8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int n, input bit s, input logic [7:0] a, input logic [7:0] b);
        if (n == 4) begin
            start4 = s; a4 = a[3:0]; b4 = b[3:0];
        end else begin
            start8 = s; a8 = a; b8 = b;
        end
    endtask

    function automatic logic [15:0] p_of(input int n);
        return (n == 4) ? {8'h00, p4} : p8;
    endfunction

    function automatic logic done_of(input int n);
        return (n == 4) ? done4 : done8;
    endfunction

    // One N=4 product: latency in negedges after the accepting edge, busy cycles, result, hold.
    task automatic single_op(input string tag, input logic [3:0] a, input logic [3:0] b);
        int lat, busy_cnt;
        bit zero;
        logic [7:0] held;
        zero = (a == 0) || (b == 0);
        @(negedge clk) drive(4, 1'b1, {4'h0, a}, {4'h0, b});
        @(negedge clk) drive(4, 1'b0, 8'($urandom), 8'($urandom));
        lat = 1;
        busy_cnt = 0;
        while (!done4 && lat < 20) begin
            busy_cnt += int'(busy4);
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, (SKIP && zero) ? 1 : 5);
        check({tag, "_busy"}, busy_cnt, (SKIP && zero) ? 0 : 4);
        check({tag, "_p"}, p4, 32'(a) * 32'(b));
        held = p4;
        @(negedge clk);
        check({tag, "_done_pulse"}, done4, 0);
        check({tag, "_p_hold"}, p4, held);
    endtask

    // start held high: each product presented on the done cycle, checked on its own done.
    task automatic stream(input int n, input int count, input bit exh);
        logic [15:0] exp_q[$];
        bit          zero_q[$];
        logic [7:0]  a, b;
        logic [15:0] e;
        bit          z;
        int          issued, seen, gap, guard;
        int          mask;
        mask = (1 << n) - 1;
        issued = 0; seen = 0; gap = 0; guard = 0;
        a = exh ? 8'(0) : 8'($urandom) & 8'(mask);
        b = exh ? 8'(0) : 8'($urandom) & 8'(mask);
        @(negedge clk) drive(n, 1'b1, a, b);
        exp_q.push_back(16'(a) * 16'(b));
        zero_q.push_back(a == 0 || b == 0);
        issued = 1;
        while (seen < count && guard < count * (n + 2) + 20) begin
            @(negedge clk);
            gap++;
            guard++;
            if (done_of(n)) begin
                e = exp_q.pop_front();
                z = zero_q.pop_front();
                check($sformatf("stream%0d_p", n), p_of(n), e);
                check($sformatf("stream%0d_gap", n), gap, (SKIP && z) ? 1 : n + 1);
                seen++;
                gap = 0;
                if (issued < count) begin
                    a = exh ? 8'(issued >> 4) : 8'($urandom) & 8'(mask);
                    b = exh ? 8'(issued & 15) : 8'($urandom) & 8'(mask);
                    drive(n, 1'b1, a, b);
                    exp_q.push_back(16'(a) * 16'(b));
                    zero_q.push_back(a == 0 || b == 0);
                    issued++;
                end else begin
                    drive(n, 1'b0, 8'h00, 8'h00);
                end
            end else begin
                drive(n, 1'b1, 8'($urandom), 8'($urandom));
            end
        end
        check($sformatf("stream%0d_count", n), seen, count);
        drive(n, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int pulses;
        repeat (2) @(negedge clk);
        check("rst_p", p4, 0);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        rst_n = 1'b1;
        @(negedge clk);

        single_op("m3x5", 4'd3, 4'd5);
        single_op("m15x15", 4'd15, 4'd15);
        single_op("m15x1", 4'd15, 4'd1);
        single_op("m1x15", 4'd1, 4'd15);
        single_op("m0x9", 4'd0, 4'd9);
        for (int i = 0; i < 6; i++) begin
            single_op("mrand", 4'($urandom), 4'($urandom));
        end

        // start pulses mid-CALC with other operands must be ignored
        @(negedge clk) drive(4, 1'b1, 8'd3, 8'd5);
        @(negedge clk) drive(4, 1'b0, 8'd9, 8'd9);
        @(negedge clk) drive(4, 1'b1, 8'd9, 8'd9);
        @(negedge clk) drive(4, 1'b1, 8'd7, 8'd11);
        @(negedge clk) drive(4, 1'b0, 8'd0, 8'd0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (done4) begin
                pulses++;
                check("ign_p", p4, 8'h0F);
            end
            @(negedge clk);
        end
        check("ign_pulses", pulses, 1);

        // asynchronous reset in cycle 2 of CALC
        @(negedge clk) drive(4, 1'b1, 8'd3, 8'd5);
        @(negedge clk) drive(4, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_p", p4, 0);
        check("arst_busy", busy4, 0);
        check("arst_done", done4, 0);
        @(negedge clk) rst_n = 1'b1;
        single_op("m7x6", 4'd7, 4'd6);

        stream(4, 256, 1'b1);
        stream(8, 150, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
